voice_allocator: RTL and testbench

//  Parametrised polyphonic front end for the keyboard synthesiser: consumes the PS/2 byte stream
//  (make, F0 break, E0 extended), maps note keys to tone steps, and allocates notes to NUM_CH

---
 rtl/voice_allocator_pkg.sv | 37 +++
 rtl/voice_allocator_if.sv | 29 ++
 rtl/voice_allocator_note_lut.sv | 28 ++
 rtl/voice_allocator.sv | 171 +++++++++++++++++
 tb/tb_voice_allocator.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared note definitions for the keyboard synthesiser front end.
//  - PS/2 set-2 prefix bytes (break F0, extended E0)
//  - note-key scan-code table and matching tone-step values (index 0 = -#4 .. 19 = +#1)
//  - idle step value driven on an unused voice
//  - parser state encoding
// The staff display reuses NOTE_CODE / NOTE_TBL_CNT for key positions.
package voice_allocator_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;

    localparam int NOTE_TBL_CNT = 20;
    localparam int NOTE_STEP_W  = 11;   // widest table step (1198) fits in 11 bits

    localparam logic [NOTE_STEP_W-1:0] IDLE_STEP = 11'd1;

    localparam logic [7:0] NOTE_CODE [NOTE_TBL_CNT] = '{
        8'h15, 8'h1c, 8'h1d, 8'h1b, 8'h24, 8'h23, 8'h2b, 8'h2c, 8'h34, 8'h35,
        8'h33, 8'h3b, 8'h43, 8'h42, 8'h44, 8'h4b, 8'h4d, 8'h4c, 8'h52, 8'h5b
    };

    localparam logic [NOTE_STEP_W-1:0] NOTE_STEP [NOTE_TBL_CNT] = '{
        11'd400,  11'd423,  11'd448,  11'd475,  11'd503,
        11'd533,  11'd565,  11'd599,  11'd634,  11'd672,
        11'd712,  11'd755,  11'd800,  11'd847,  11'd897,
        11'd951,  11'd1007, 11'd1067, 11'd1131, 11'd1198
    };

    // Parser state: the two prefix flags (extended, break) folded into one enum.
    typedef enum logic [1:0] {
        P_IDLE    = 2'b00,
        P_BRK     = 2'b01,
        P_EXT     = 2'b10,
        P_EXT_BRK = 2'b11
    } parse_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Byte-stream in / voice state out bundle of the voice allocator.
//  scan_valid, scan_code : PS/2 byte strobe and byte (from the receiver)
//  ch_step, ch_gate      : per-voice tone step and gate (to the tone generators)
//  key_down              : per-note held bitmap (to the staff display)
//  alloc_evt, overflow   : one-cycle event pulses
// master = PS/2 side / observer, slave = the allocator.
interface voice_allocator_if #(
    parameter int NUM_CH   = 4,
    parameter int STEP_W   = 16,
    parameter int NOTE_CNT = 20
);
    logic                       scan_valid;
    logic [7:0]                 scan_code;
    logic [NUM_CH*STEP_W-1:0]   ch_step;
    logic [NUM_CH-1:0]          ch_gate;
    logic [NOTE_CNT-1:0]        key_down;
    logic                       alloc_evt;
    logic                       overflow;

    modport master (
        output scan_valid, scan_code,
        input  ch_step, ch_gate, key_down, alloc_evt, overflow
    );

    modport slave (
        input  scan_valid, scan_code,
        output ch_step, ch_gate, key_down, alloc_evt, overflow
    );
endinterface

// File: rtl/voice_allocator_note_lut.sv
// note_lut: combinational scan-code -> note lookup.
//  scan_code in  8       PS/2 byte
//  hit       out 1       byte is a note key
//  index     out 5       note index 0..19 (0 on miss)
//  step      out STEP_W  zero-extended tone step (idle step on miss)
module note_lut
    import voice_allocator_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic [7:0]        scan_code,
    output logic              hit,
    output logic [4:0]        index,
    output logic [STEP_W-1:0] step
);
    always_comb begin
        hit   = 1'b0;
        index = '0;
        step  = STEP_W'(IDLE_STEP);
        for (int i = 0; i < NOTE_TBL_CNT; i++) begin
            if (scan_code == NOTE_CODE[i]) begin
                hit   = 1'b1;
                index = 5'(i);
                step  = STEP_W'(NOTE_STEP[i]);
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: PS/2 byte parser + polyphonic voice allocation.
//  clk, reset : single clock, synchronous active-high reset
//  bus        : voice_allocator_if.slave (byte stream in, voice/key state and pulses out)
// A terminal byte is acted on in its scan_valid cycle; all outputs are registered,
// so results appear one clock later. Free voices are taken lowest-index first;
// when all are busy the voice with the highest age rank (oldest) is stolen, or the
// note is dropped with an overflow pulse when stealing is disabled.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int STEP_W   = 16,
    parameter int NOTE_CNT = 20,
    parameter int STEAL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    voice_allocator_if.slave  bus
);
    localparam int RW = $clog2(NUM_CH);

    generate
        if (STEP_W < NOTE_STEP_W) begin : g_bad_step_w
            $error("voice_allocator: STEP_W must be at least 11");
        end
        if (NOTE_CNT != NOTE_TBL_CNT) begin : g_bad_note_cnt
            $error("voice_allocator: NOTE_CNT must match the note table");
        end
        if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
            $error("voice_allocator: NUM_CH must be 2..8");
        end
    endgenerate

    parse_state_t          state_reg;
    logic [NOTE_CNT-1:0]   key_down_reg;
    logic                  alloc_evt_reg;
    logic                  overflow_reg;

    logic [NUM_CH-1:0]             gate_vec;
    logic [NUM_CH-1:0][4:0]        owner_all;
    logic [NUM_CH-1:0][RW-1:0]     rank_all;

    logic              lut_hit;
    logic [4:0]        lut_idx;
    logic [STEP_W-1:0] lut_step;

    note_lut #(.STEP_W(STEP_W)) u_lut (
        .scan_code (bus.scan_code),
        .hit       (lut_hit),
        .index     (lut_idx),
        .step      (lut_step)
    );

    logic is_prefix, ext_flag, brk_flag, note_evt, press_req, release_req;
    assign is_prefix   = (bus.scan_code == SC_BREAK) || (bus.scan_code == SC_EXTENDED);
    assign ext_flag    = (state_reg == P_EXT) || (state_reg == P_EXT_BRK);
    assign brk_flag    = (state_reg == P_BRK) || (state_reg == P_EXT_BRK);
    assign note_evt    = bus.scan_valid && !is_prefix && lut_hit && !ext_flag;
    // A make for an already-held note is typematic repeat and is ignored.
    assign press_req   = note_evt && !brk_flag && !key_down_reg[lut_idx];
    assign release_req = note_evt && brk_flag;

    logic              free_found;
    logic [RW-1:0]     free_idx, oldest_idx, tgt_idx, tgt_rank;
    logic [4:0]        displaced;
    logic              do_press, do_overflow, do_steal;
    logic [NUM_CH-1:0] rel_hit;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        // Descending scan so the lowest free index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!gate_vec[i]) begin
                free_found = 1'b1;
                free_idx   = RW'(i);
            end
        end
        oldest_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rank_all[i] == RW'(NUM_CH - 1)) begin
                oldest_idx = RW'(i);
            end
        end
        tgt_idx     = free_found ? free_idx : oldest_idx;
        tgt_rank    = rank_all[tgt_idx];
        displaced   = owner_all[tgt_idx];
        do_press    = press_req && (free_found || (STEAL_EN != 0));
        do_overflow = press_req && !free_found && (STEAL_EN == 0);
        do_steal    = do_press && !free_found;
        for (int i = 0; i < NUM_CH; i++) begin
            rel_hit[i] = release_req && gate_vec[i] && (owner_all[i] == lut_idx);
        end
    end

    // Per-voice state. Ranks form a permutation: the target drops to 0 and every
    // voice younger than the target's old rank ages by one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_voice
            logic [STEP_W-1:0] step_reg;
            logic              gate_reg;
            logic [4:0]        owner_reg;
            logic [RW-1:0]     rank_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    step_reg  <= STEP_W'(IDLE_STEP);
                    gate_reg  <= 1'b0;
                    owner_reg <= '0;
                    rank_reg  <= RW'(gi);
                end else if (do_press && (tgt_idx == RW'(gi))) begin
                    step_reg  <= lut_step;
                    gate_reg  <= 1'b1;
                    owner_reg <= lut_idx;
                    rank_reg  <= '0;
                end else begin
                    if (do_press && (rank_reg < tgt_rank)) begin
                        rank_reg <= rank_reg + RW'(1);
                    end
                    if (rel_hit[gi]) begin
                        gate_reg <= 1'b0;
                        step_reg <= STEP_W'(IDLE_STEP);
                    end
                end
            end

            assign bus.ch_step[gi*STEP_W +: STEP_W] = step_reg;
            assign gate_vec[gi]  = gate_reg;
            assign owner_all[gi] = owner_reg;
            assign rank_all[gi]  = rank_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= P_IDLE;
            key_down_reg  <= '0;
            alloc_evt_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            alloc_evt_reg <= do_press;
            overflow_reg  <= do_overflow;
            if (bus.scan_valid) begin
                if (bus.scan_code == SC_EXTENDED) begin
                    state_reg <= brk_flag ? P_EXT_BRK : P_EXT;
                end else if (bus.scan_code == SC_BREAK) begin
                    state_reg <= ext_flag ? P_EXT_BRK : P_BRK;
                end else begin
                    state_reg <= P_IDLE;
                end
            end
            // Displaced note is cleared first; the new note (never equal to it) is set after.
            if (do_steal) begin
                key_down_reg[displaced] <= 1'b0;
            end
            if (do_press) begin
                key_down_reg[lut_idx] <= 1'b1;
            end
            if (|rel_hit) begin
                key_down_reg[lut_idx] <= 1'b0;
            end
        end
    end

    assign bus.ch_gate   = gate_vec;
    assign bus.key_down  = key_down_reg;
    assign bus.alloc_evt = alloc_evt_reg;
    assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: two instances (stealing on / off) receive the
// same byte stream; expected values are hand-computed from the note table.
module tb_voice_allocator;
    localparam int NUM_CH   = 4;
    localparam int STEP_W   = 16;
    localparam int NOTE_CNT = 20;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    voice_allocator_if #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .NOTE_CNT(NOTE_CNT)) va_steal ();
    voice_allocator_if #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .NOTE_CNT(NOTE_CNT)) va_drop ();

    voice_allocator #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .NOTE_CNT(NOTE_CNT), .STEAL_EN(1)) dut_steal (
        .clk   (clk),
        .reset (reset),
        .bus   (va_steal.slave)
    );

    voice_allocator #(.NUM_CH(NUM_CH), .STEP_W(STEP_W), .NOTE_CNT(NOTE_CNT), .STEAL_EN(0)) dut_drop (
        .clk   (clk),
        .reset (reset),
        .bus   (va_drop.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One byte to both instances; returns on the falling edge after the capture edge.
    task automatic send(input logic [7:0] code);
        va_steal.scan_valid = 1'b1;
        va_steal.scan_code  = code;
        va_drop.scan_valid  = 1'b1;
        va_drop.scan_code   = code;
        @(negedge clk);
        va_steal.scan_valid = 1'b0;
        va_drop.scan_valid  = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    function automatic logic [STEP_W-1:0] step_of(input logic [NUM_CH*STEP_W-1:0] v, input int i);
        return v[i*STEP_W +: STEP_W];
    endfunction

    function automatic logic [NOTE_CNT-1:0] kd(input int a, input int b, input int c, input int d);
        logic [NOTE_CNT-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        va_steal.scan_valid = 1'b0;
        va_steal.scan_code  = 8'h00;
        va_drop.scan_valid  = 1'b0;
        va_drop.scan_code   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle();

        // Reset state
        check("rst_gate",  va_steal.ch_gate, 4'b0000);
        check("rst_step",  va_steal.ch_step, {4{16'd1}});
        check("rst_keys",  va_steal.key_down, '0);
        check("rst_alloc", va_steal.alloc_evt, 1'b0);
        check("rst_ovf",   va_drop.overflow, 1'b0);

        // 1: single press
        send(8'h2b);
        check("t1_gate",  va_steal.ch_gate, 4'b0001);
        check("t1_step0", step_of(va_steal.ch_step, 0), 16'd565);
        check("t1_keys",  va_steal.key_down, kd(6, -1, -1, -1));
        check("t1_alloc", va_steal.alloc_evt, 1'b1);
        idle();
        check("t1_alloc_end", va_steal.alloc_evt, 1'b0);

        // 4: typematic repeat, back-to-back bytes
        send(8'h2b);
        check("t4_alloc_a", va_steal.alloc_evt, 1'b0);
        send(8'h2b);
        check("t4_alloc_b", va_steal.alloc_evt, 1'b0);
        check("t4_gate",    va_steal.ch_gate, 4'b0001);

        // 5: extended break ignored, then a real break
        send(8'he0);
        send(8'hf0);
        send(8'h2b);
        check("t5_ext_gate",  va_steal.ch_gate, 4'b0001);
        check("t5_ext_step0", step_of(va_steal.ch_step, 0), 16'd565);
        send(8'hf0);
        check("t5_prefix_gate", va_steal.ch_gate, 4'b0001);
        send(8'h2b);
        check("t5_rel_gate",  va_steal.ch_gate, 4'b0000);
        check("t5_rel_step0", step_of(va_steal.ch_step, 0), 16'd1);
        check("t5_rel_keys",  va_steal.key_down, '0);
        check("t5_rel_alloc", va_steal.alloc_evt, 1'b0);
        idle();

        // 2 / 3: fill all four voices, then one more note
        send(8'h2b);
        send(8'h34);
        send(8'h33);
        send(8'h3b);
        check("t2_full_gate", va_steal.ch_gate, 4'b1111);
        check("t2_full_step", va_steal.ch_step, {16'd755, 16'd712, 16'd634, 16'd565});
        check("t2_full_keys", va_steal.key_down, kd(6, 8, 10, 11));
        send(8'h42);
        check("t2_steal_step0", step_of(va_steal.ch_step, 0), 16'd847);
        check("t2_steal_keys",  va_steal.key_down, kd(8, 10, 11, 13));
        check("t2_steal_alloc", va_steal.alloc_evt, 1'b1);
        check("t2_steal_ovf",   va_steal.overflow, 1'b0);
        check("t3_drop_ovf",    va_drop.overflow, 1'b1);
        check("t3_drop_alloc",  va_drop.alloc_evt, 1'b0);
        check("t3_drop_gate",   va_drop.ch_gate, 4'b1111);
        check("t3_drop_step",   va_drop.ch_step, {16'd755, 16'd712, 16'd634, 16'd565});
        check("t3_drop_keys",   va_drop.key_down, kd(6, 8, 10, 11));
        idle();
        check("t3_ovf_end", va_drop.overflow, 1'b0);

        // Release of a stolen note does nothing; without stealing it frees voice 0
        send(8'hf0);
        send(8'h2b);
        check("t2_stolen_rel_gate",  va_steal.ch_gate, 4'b1111);
        check("t2_stolen_rel_step0", step_of(va_steal.ch_step, 0), 16'd847);
        check("t2_stolen_rel_keys",  va_steal.key_down, kd(8, 10, 11, 13));
        check("t3_rel_gate",  va_drop.ch_gate, 4'b1110);
        check("t3_rel_step0", step_of(va_drop.ch_step, 0), 16'd1);

        // Next steal takes voice 1 (now oldest); drop instance refills free voice 0
        send(8'h44);
        check("t2_steal2_step1", step_of(va_steal.ch_step, 1), 16'd897);
        check("t2_steal2_keys",  va_steal.key_down, kd(10, 11, 13, 14));
        check("t3_refill_step0", step_of(va_drop.ch_step, 0), 16'd897);
        check("t3_refill_gate",  va_drop.ch_gate, 4'b1111);

        // Unknown code: consumed, no action even with all voices busy
        send(8'h5a);
        check("unk_alloc", va_steal.alloc_evt, 1'b0);
        check("unk_ovf",   va_drop.overflow, 1'b0);

        // 6: reset discards a pending break prefix
        send(8'hf0);
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
        check("t6_rst_gate", va_steal.ch_gate, 4'b0000);
        send(8'h2b);
        check("t6_gate",  va_steal.ch_gate, 4'b0001);
        check("t6_step0", step_of(va_steal.ch_step, 0), 16'd565);
        check("t6_keys",  va_steal.key_down, kd(6, -1, -1, -1));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
